// File: rtl/regfile_alu_sequencer.sv
// Four-state sequencer: read two registers, apply a 2-bit ALU op, write the result back.
// Optional REG_ZERO_EN makes register 0 read as zero and suppresses writes to it.
module regfile_alu_sequencer #(
    parameter int word_size = 32,
    parameter int addr_size = 5
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Cmd_Valid,
    output logic                 Cmd_Ready,
    input  logic [1:0]           Cmd_Op,
    input  logic [addr_size-1:0] Cmd_Rd,
    input  logic [addr_size-1:0] Cmd_Rs1,
    input  logic [addr_size-1:0] Cmd_Rs2,
    output logic [addr_size-1:0] Read_Addr_1,
    output logic [addr_size-1:0] Read_Addr_2,
    input  logic [word_size-1:0] Data_Out_1,
    input  logic [word_size-1:0] Data_Out_2,
    output logic [addr_size-1:0] Write_Addr,
    output logic [word_size-1:0] Data_In,
    output logic                 Write_Enable,
    output logic                 Done,
    output logic [word_size-1:0] Result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [1:0]           op_r;
    logic [addr_size-1:0] rd_r;
    logic [addr_size-1:0] rs1_r;
    logic [addr_size-1:0] rs2_r;
    logic [word_size-1:0] opa_r;
    logic [word_size-1:0] opb_r;
    logic [word_size-1:0] result_r;
    logic                 handshake_s;
    logic                 rd_writable_s;

    function automatic logic [word_size-1:0] alu_calc(
        input logic [1:0]           op,
        input logic [word_size-1:0] a,
        input logic [word_size-1:0] b
    );
        logic [word_size-1:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            2'b11:   r = a ^ b;
            default: r = {word_size{1'b0}};
        endcase
        return r;
    endfunction

    // Source address 0 reads as zero only when the zero-register option is built in.
    function automatic logic [word_size-1:0] read_operand(
        input logic [addr_size-1:0] addr,
        input logic [word_size-1:0] data
    );
        logic [word_size-1:0] v;
`ifdef REG_ZERO_EN
        if (addr == {addr_size{1'b0}}) begin
            v = {word_size{1'b0}};
        end else begin
            v = data;
        end
`else
        v = data;
        if (addr == {addr_size{1'b0}}) begin
            v = data;
        end
`endif
        return v;
    endfunction

    assign handshake_s = Cmd_Valid && (state_r == IDLE);

`ifdef REG_ZERO_EN
    assign rd_writable_s = (rd_r != {addr_size{1'b0}});
`else
    assign rd_writable_s = 1'b1;
`endif

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: fixed IDLE->READ->EXEC->WRITE ring, IDLE waits for a handshake
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Cmd_Valid) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ:    state_s = EXEC;
            EXEC:    state_s = WRITE;
            WRITE:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Command latch, operand capture and result register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_r     <= 2'b00;
            rd_r     <= {addr_size{1'b0}};
            rs1_r    <= {addr_size{1'b0}};
            rs2_r    <= {addr_size{1'b0}};
            opa_r    <= {word_size{1'b0}};
            opb_r    <= {word_size{1'b0}};
            result_r <= {word_size{1'b0}};
        end else begin
            if (handshake_s) begin
                op_r  <= Cmd_Op;
                rd_r  <= Cmd_Rd;
                rs1_r <= Cmd_Rs1;
                rs2_r <= Cmd_Rs2;
            end
            if (state_r == READ) begin
                opa_r <= read_operand(rs1_r, Data_Out_1);
                opb_r <= read_operand(rs2_r, Data_Out_2);
            end
            if (state_r == EXEC) begin
                result_r <= alu_calc(op_r, opa_r, opb_r);
            end
        end
    end

    // Output decode; the write strobe is gated by Reset so a mid-WRITE reset never writes
    always_comb begin
        Cmd_Ready    = 1'b0;
        Read_Addr_1  = {addr_size{1'b0}};
        Read_Addr_2  = {addr_size{1'b0}};
        Write_Enable = 1'b0;
        Done         = 1'b0;
        case (state_r)
            IDLE: begin
                Cmd_Ready = 1'b1;
            end
            READ: begin
                Read_Addr_1 = rs1_r;
                Read_Addr_2 = rs2_r;
            end
            EXEC: begin
                Cmd_Ready = 1'b0;
            end
            WRITE: begin
                Done         = 1'b1;
                Write_Enable = rd_writable_s && !Reset;
            end
            default: begin
                Cmd_Ready = 1'b0;
            end
        endcase
    end

    assign Write_Addr = rd_r;
    assign Data_In    = result_r;
    assign Result     = result_r;

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Directed bench: behavioural register file around the sequencer, scoreboard of expected writes.
module tb_regfile_alu_sequencer;

    localparam int W = 32;
    localparam int A = 5;

    logic         Clock;
    logic         Reset;
    logic         Cmd_Valid;
    logic         Cmd_Ready;
    logic [1:0]   Cmd_Op;
    logic [A-1:0] Cmd_Rd;
    logic [A-1:0] Cmd_Rs1;
    logic [A-1:0] Cmd_Rs2;
    logic [A-1:0] Read_Addr_1;
    logic [A-1:0] Read_Addr_2;
    logic [W-1:0] Data_Out_1;
    logic [W-1:0] Data_Out_2;
    logic [A-1:0] Write_Addr;
    logic [W-1:0] Data_In;
    logic         Write_Enable;
    logic         Done;
    logic [W-1:0] Result;

    logic [W-1:0] rf [0:31];
    logic [W-1:0] shadow [0:31];
    logic         pl_en;
    logic [A-1:0] pl_addr;
    logic [W-1:0] pl_data;

    logic [W-1:0] exp_q [$];
    logic [A-1:0] rd_q [$];

    int tests;
    int failed;

    regfile_alu_sequencer #(.word_size(W), .addr_size(A)) dut (
        .Clock(Clock), .Reset(Reset),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
        .Cmd_Op(Cmd_Op), .Cmd_Rd(Cmd_Rd), .Cmd_Rs1(Cmd_Rs1), .Cmd_Rs2(Cmd_Rs2),
        .Read_Addr_1(Read_Addr_1), .Read_Addr_2(Read_Addr_2),
        .Data_Out_1(Data_Out_1), .Data_Out_2(Data_Out_2),
        .Write_Addr(Write_Addr), .Data_In(Data_In), .Write_Enable(Write_Enable),
        .Done(Done), .Result(Result)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign Data_Out_1 = rf[Read_Addr_1];
    assign Data_Out_2 = rf[Read_Addr_2];

    // Behavioural register file: DUT writes, plus a bench-side preload port
    always @(posedge Clock) begin
        if (Write_Enable) begin
            rf[Write_Addr] <= Data_In;
        end else if (pl_en) begin
            rf[pl_addr] <= pl_data;
        end
    end

    function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_read(input logic [A-1:0] addr);
`ifdef REG_ZERO_EN
        if (addr == 5'd0) return 32'd0;
`endif
        return shadow[addr];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_reg(input logic [A-1:0] a, input logic [W-1:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
        shadow[a] = d;
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [A-1:0] rd,
                           input logic [A-1:0] rs1, input logic [A-1:0] rs2, input bit expect_we);
        int n;
        logic [W-1:0] expv;
        logic [A-1:0] exp_rd;
        n = 0;
        while (!Cmd_Ready && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, {31'd0, Cmd_Ready}, 32'd1);
        exp_q.push_back(ref_alu(op, ref_read(rs1), ref_read(rs2)));
        rd_q.push_back(rd);
        Cmd_Valid = 1'b1;
        Cmd_Op = op;
        Cmd_Rd = rd;
        Cmd_Rs1 = rs1;
        Cmd_Rs2 = rs2;
        tick();
        // Keep offering junk while busy: it must be ignored
        Cmd_Op = 2'($urandom);
        Cmd_Rd = 5'($urandom);
        Cmd_Rs1 = 5'($urandom);
        Cmd_Rs2 = 5'($urandom);
        check({tag, "_raddr1"}, {27'd0, Read_Addr_1}, {27'd0, rs1});
        check({tag, "_raddr2"}, {27'd0, Read_Addr_2}, {27'd0, rs2});
        check({tag, "_busy"}, {31'd0, Cmd_Ready}, 32'd0);
        n = 0;
        do begin
            tick();
            n++;
            if (!Done) check({tag, "_raddr_exec"}, {27'd0, Read_Addr_1}, 32'd0);
        end while (!Done && n < 6);
        Cmd_Valid = 1'b0;
        check({tag, "_latency"}, n, 32'd2);
        expv = exp_q.pop_front();
        exp_rd = rd_q.pop_front();
        check({tag, "_waddr"}, {27'd0, Write_Addr}, {27'd0, exp_rd});
        check({tag, "_data_in"}, Data_In, expv);
        check({tag, "_we"}, {31'd0, Write_Enable}, {31'd0, expect_we});
        if (expect_we) shadow[exp_rd] = expv;
        tick();
        check({tag, "_done_off"}, {31'd0, Done}, 32'd0);
        check({tag, "_we_off"}, {31'd0, Write_Enable}, 32'd0);
        check({tag, "_ready_again"}, {31'd0, Cmd_Ready}, 32'd1);
        check({tag, "_result_hold"}, Result, expv);
        check({tag, "_rf"}, rf[exp_rd], shadow[exp_rd]);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        pl_en = 1'b0;
        pl_addr = 5'd0;
        pl_data = 32'd0;
        Cmd_Valid = 1'b0;
        Cmd_Op = 2'b00;
        Cmd_Rd = 5'd0;
        Cmd_Rs1 = 5'd0;
        Cmd_Rs2 = 5'd0;
        for (int i = 0; i < 32; i++) begin
            rf[i] = 32'd0;
            shadow[i] = 32'd0;
        end
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_ready", {31'd0, Cmd_Ready}, 32'd1);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_we", {31'd0, Write_Enable}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_raddr", {22'd0, Read_Addr_1, Read_Addr_2}, 32'd0);
        check("rst_waddr", {27'd0, Write_Addr}, 32'd0);
        check("rst_data_in", Data_In, 32'd0);

        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd7);
        run_cmd("add", 2'b00, 5'd3, 5'd1, 5'd2, 1'b1);
        check("add_value", rf[3], 32'd12);

        set_reg(5'd1, 32'd0);
        set_reg(5'd2, 32'd1);
        run_cmd("sub", 2'b01, 5'd4, 5'd1, 5'd2, 1'b1);
        check("sub_value", rf[4], 32'hFFFF_FFFF);

        set_reg(5'd1, 32'hF0F0_F0F0);
        set_reg(5'd2, 32'hFF00_FF00);
        run_cmd("and", 2'b10, 5'd7, 5'd1, 5'd2, 1'b1);
        check("and_value", rf[7], 32'hF000_F000);
        run_cmd("xor", 2'b11, 5'd8, 5'd1, 5'd2, 1'b1);
        check("xor_value", rf[8], 32'h0FF0_0FF0);

        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd7);
        run_cmd("b2b_a", 2'b00, 5'd5, 5'd1, 5'd2, 1'b1);
        run_cmd("b2b_b", 2'b00, 5'd6, 5'd5, 5'd5, 1'b1);
        check("b2b_value", rf[6], 32'd24);

        run_cmd("rd_eq_rs", 2'b00, 5'd1, 5'd1, 5'd1, 1'b1);
        check("rd_eq_rs_value", rf[1], 32'd10);

        // Reset during WRITE must suppress the register write
        set_reg(5'd9, 32'h0000_AAAA);
        Cmd_Valid = 1'b1;
        Cmd_Op = 2'b00;
        Cmd_Rd = 5'd9;
        Cmd_Rs1 = 5'd1;
        Cmd_Rs2 = 5'd2;
        tick();
        Cmd_Valid = 1'b0;
        tick();
        tick();
        check("midrst_in_write", {31'd0, Done}, 32'd1);
        Reset = 1'b1;
        #1;
        check("midrst_we_gated", {31'd0, Write_Enable}, 32'd0);
        tick();
        Reset = 1'b0;
        check("midrst_ready", {31'd0, Cmd_Ready}, 32'd1);
        check("midrst_done", {31'd0, Done}, 32'd0);
        check("midrst_result", Result, 32'd0);
        check("midrst_rf", rf[9], 32'h0000_AAAA);

        // Reset wins over a simultaneous handshake
        Reset = 1'b1;
        Cmd_Valid = 1'b1;
        tick();
        Reset = 1'b0;
        Cmd_Valid = 1'b0;
        check("rst_vs_hs_ready", {31'd0, Cmd_Ready}, 32'd1);
        check("rst_vs_hs_raddr", {27'd0, Read_Addr_1}, 32'd0);

        set_reg(5'd0, 32'd9);
`ifdef REG_ZERO_EN
        run_cmd("zero", 2'b00, 5'd0, 5'd0, 5'd2, 1'b0);
        check("zero_result", Result, 32'd7);
        check("zero_r0_kept", rf[0], 32'd9);
`else
        run_cmd("zero", 2'b00, 5'd0, 5'd0, 5'd2, 1'b1);
        check("zero_result", Result, 32'd16);
        check("zero_r0_written", rf[0], 32'd16);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
